adder_pipe: RTL
===============

# adder_pipe

Parametrised, pipelined two's-complement adder/subtractor with valid/ready flow control. It is the successor of the fixed-width combinational ripple adders and serves as the datapath add unit for the ALU and address paths. The carry chain is split into `STAGES` equal slices, with one slice per clock. Throughput is one operation per cycle when unstalled.

## Interface
- `WIDTH`, default 16, is the operand and result width in bits. It must be at least 2 and divisible by `STAGES`.
- `STAGES`, default 4, is the number of pipeline stages and carry slices. The legal range is 1..`WIDTH`. The slice width is `SW = WIDTH/STAGES`.
- `clk` input, 1 bit: the single clock. Everything is rising-edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: the operand beat is valid.
- `in_ready` output, 1 bit: the block accepts a beat this cycle.
- `a` input, `WIDTH` bits, signed: operand A.
- `b` input, `WIDTH` bits, signed: operand B.
- `cin` input, 1 bit: carry-in. It is ignored when `sub=1`.
- `sub` input, 1 bit: `0` selects A+B+cin, `1` selects A−B.
- `out_valid` output, 1 bit: the result beat is valid.
- `out_ready` input, 1 bit: the consumer accepts the result.
- `sum` output, `WIDTH` bits, signed: the result.
- `cout` output, 1 bit: carry out of bit `WIDTH-1`.
- `ovf` output, 1 bit: signed overflow.

## Operation
- Effective operands:
  - With `sub=0`: `B' = b` and `c0 = cin`.
  - With `sub=1`: `B' = ~b` and `c0 = 1`.
- Stage k (k = 0..STAGES-1) adds slice bits `[k*SW +: SW]` of A and B', using the carry registered by stage k-1 (or `c0` for k=0).
  - Upper slices not yet consumed travel alongside in skew registers.
  - Completed lower sum slices travel forward in their own registers.
- Result width rules:
  - `sum` is (A + B' + c0) mod 2^WIDTH.
  - `cout` is bit `WIDTH` of the full sum. For a subtract, `cout=1` means no borrow.
  - `ovf = (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1])`, computed on the unsaturated sum.
- Flow control uses a global stall:
  - `adv = !out_valid || out_ready`.
  - `in_ready = adv`.
  - When `adv=1`, every stage register loads from its predecessor, and each stage valid bit loads its predecessor's valid bit. Stage 0 loads `in_valid`.
  - When `adv=0`, all stage registers hold.
  - Bubbles propagate as valid=0 and are squeezed only at the output: a stage holding valid=0 still shifts.
- A beat is accepted when `in_valid && in_ready` and is delivered when `out_valid && out_ready`. Ordering is strictly FIFO, and no beat is dropped or duplicated.
- `sum`, `cout` and `ovf` are driven from the last stage registers. They are stable while `out_valid && !out_ready`.

## Timing
- Reset (`rst_n=0`, asynchronous):
  - All valid bits go to 0, so `out_valid=0`.
  - `sum=0`, `cout=0`, `ovf=0`.
  - `in_ready=1` as soon as reset is asserted.
- Reset asserted mid-operation discards every in-flight beat. After release, the first accepted beat appears `STAGES` cycles later.
- Latency: a beat accepted at rising edge N shows `out_valid=1` after edge N+STAGES−1, i.e. `STAGES` cycles. When `STAGES=1`, the result is registered one cycle after acceptance.
- Throughput is 1 beat/cycle while `out_ready=1`.
- Full pipeline with `out_valid=1, out_ready=0`:
  - `in_ready=0`.
  - Nothing moves.
  - Inputs are ignored.
- Full pipeline with `out_ready=1` and `in_valid=1` in the same cycle: the output drains and the input enters on the same edge.
- `in_ready` depends combinationally on `out_ready`. This is the only combinational input-to-output path.
- `in_valid` may drop at any time without a handshake penalty.

## Configuration
- `ADDER_PIPE_SAT_EN` defined: signed saturation on the result.
  - When `ovf=1`, `sum` is clamped to 2^(W−1)−1 if `A[W-1]=0`, or to −2^(W−1) if `A[W-1]=1`.
  - `ovf` still reports the overflow.
  - `cout` is unchanged, taken from the raw sum.
  - Saturation is applied in the last stage and adds no latency.
- `ADDER_PIPE_SAT_EN` undefined: `sum` wraps modulo 2^WIDTH and there is no clamp logic.

## Test plan
All scenarios use `WIDTH=16`, `STAGES=4`.

- **Basic add:** a=0x1234, b=0x0FF0, cin=1, sub=0, `out_ready=1`.
  - Response 4 cycles later: sum=0x2225, cout=0, ovf=0.
- **Carry across all slices:** a=0xFFFF, b=0x0001, cin=0.
  - Response: sum=0x0000, cout=1, ovf=0.
- **Subtract and signed overflow:** a=0x8000, b=0x0001, sub=1.
  - Response with the macro undefined: sum=0x7FFF, cout=1, ovf=1.
  - Response with `ADDER_PIPE_SAT_EN` defined: sum=0x8000, ovf=1.
- **Back-to-back stream:** 8 consecutive beats (a=i, b=0x0100·i), `out_ready=1`.
  - Response: 8 results on 8 consecutive cycles, starting 4 cycles after the first beat, in order.
- **Backpressure:** hold `out_ready=0` from the first result onward while `in_valid=1`.
  - Required: `in_ready=0` after 4 beats are accepted, and the output holds stable.
  - On releasing `out_ready`: all beats drain in order with no loss, then one per cycle.
- **Reset mid-operation:** accept 3 beats, then pulse `rst_n=0` for half a cycle, between edges.
  - Required immediately: `out_valid=0`, sum=0, `in_ready=1`.
  - Required after release: no stale result ever appears.

Source files
------------

// File: rtl/adder_pipe.sv
// Pipelined two's-complement adder/subtractor: carry chain split into STAGES slices, one per clock,
// with global-stall valid/ready flow control. Define ADDER_PIPE_SAT_EN for signed saturation of sum.
module adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    cin,
    input  logic                    sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] sum,
    output logic                    cout,
    output logic                    ovf
);
    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    // Per-stage state: operands skew forward, finished sum slices accumulate, carry hops one slice per stage.
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  bp_q [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  a_d  [STAGES];
    logic [WIDTH-1:0]  bp_d [STAGES];
    logic [WIDTH-1:0]  s_d  [STAGES];
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] c_d;
    logic              ovf_d;

    logic [WIDTH-1:0]  pa_s [STAGES];
    logic [WIDTH-1:0]  pb_s [STAGES];
    logic [WIDTH-1:0]  ps_s [STAGES];
    logic [STAGES-1:0] pc_s;
    logic [STAGES-1:0] pv_s;
    logic              adv_s;

    assign adv_s     = !v_q[L] || out_ready;
    assign in_ready  = adv_s;
    assign out_valid = v_q[L];
    assign sum       = s_q[L];
    assign cout      = c_q[L];
    assign ovf       = ovf_q;

    // Predecessor selection: stage 0 sees the (possibly inverted) input operands, others the prior stage.
    always_comb begin
        pa_s[0] = a;
        pb_s[0] = sub ? ~b : b;
        pc_s[0] = sub ? 1'b1 : cin;
        ps_s[0] = '0;
        pv_s[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            pa_s[k] = a_q[k-1];
            pb_s[k] = bp_q[k-1];
            ps_s[k] = s_q[k-1];
            pc_s[k] = c_q[k-1];
            pv_s[k] = v_q[k-1];
        end
    end

    // Slice adders, overflow detection on the raw sum, and optional clamp in the last stage.
    always_comb begin
        logic [SW:0] slice_s;
        slice_s = '0;
        for (int k = 0; k < STAGES; k++) begin
            slice_s = {1'b0, pa_s[k][k*SW +: SW]} + {1'b0, pb_s[k][k*SW +: SW]} + {{SW{1'b0}}, pc_s[k]};
            a_d[k]  = pa_s[k];
            bp_d[k] = pb_s[k];
            s_d[k]  = ps_s[k];
            s_d[k][k*SW +: SW] = slice_s[SW-1:0];
            c_d[k]  = slice_s[SW];
            v_d[k]  = pv_s[k];
        end
        ovf_d = (pa_s[L][WIDTH-1] == pb_s[L][WIDTH-1]) && (s_d[L][WIDTH-1] != pa_s[L][WIDTH-1]);
`ifdef ADDER_PIPE_SAT_EN
        if (ovf_d) begin
            s_d[L] = pa_s[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            s_d[L] = s_d[L];
        end
`endif
    end

    // Pipeline registers: clear on reset, shift everything together on adv, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                bp_q[k] <= '0;
                s_q[k]  <= '0;
            end
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else if (adv_s) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_d[k];
                bp_q[k] <= bp_d[k];
                s_q[k]  <= s_d[k];
            end
            v_q   <= v_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end
endmodule
